fp_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `floatAdder` (IEEE-754 single precision, `a + b -> sum`) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning pair, drives the adder, registers the sum and returns it with the requester's ID on a single response channel. Only one operation is outstanding at a time. It sits between the compute clients and the floating-point adder datapath.

---
 rtl/fp_arb_pkg.sv | 40 ++++
 rtl/floatAdder.sv | 89 ++++++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fp_add_arbiter.sv | 127 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared types and helpers for the floating-point adder arbiter.
//   FP_W      - operand / result width (IEEE-754 single precision)
//   MAX_REQ   - largest requester count the round-robin helper supports
//   state_e   - sequencer states
//   rr_pick   - round-robin search returning the winner index and a found flag
package fp_arb_pkg;

  localparam int FP_W    = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... (mod n); the first asserted valid bit wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t   res;
    logic [2:0] idx;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if ((k < n) && !res.found && valid[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/floatAdder.sv
// floatAdder: combinational IEEE-754 single-precision adder, sum = a + b,
// round-to-nearest-even, with subnormal, infinity and NaN handling.
//   a, b - operands
//   sum  - rounded result
module floatAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic        swap, eff_sub, a_nan, b_nan, a_inf, b_inf, sticky, rnd_up;
  logic [31:0] big, sml;
  logic [7:0]  eb, es, diff;
  logic [26:0] mb, ms, ms_sh, mask, norm;
  logic [27:0] acc;
  logic [4:0]  lz, lz_lim;
  logic [9:0]  e, e_out;
  logic [24:0] rnd;

  always_comb begin
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // Order by magnitude so the subtraction below never borrows.
    swap = b[30:0] > a[30:0];
    big  = swap ? b : a;
    sml  = swap ? a : b;

    // Subnormals use an effective exponent of 1 and no hidden bit.
    eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    diff = eb - es;

    // Align the smaller operand; bits shifted out collapse into a sticky bit.
    mask   = '0;
    ms_sh  = '0;
    sticky = |ms;
    if (diff < 8'd27) begin
      mask   = (27'd1 << diff) - 27'd1;
      ms_sh  = ms >> diff;
      sticky = |(ms & mask);
    end
    ms_sh[0] = ms_sh[0] | sticky;

    eff_sub = big[31] ^ sml[31];
    acc     = eff_sub ? ({1'b0, mb} - {1'b0, ms_sh}) : ({1'b0, mb} + {1'b0, ms_sh});
    e       = {2'b00, eb};

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (acc[i]) lz = 5'(26 - i);
    end
    // Never normalise below exponent 1; the remainder becomes a subnormal.
    lz_lim = lz;
    if ({5'd0, lz} >= e) lz_lim = 5'(e - 10'd1);

    if (acc[27]) begin
      norm = {acc[27:2], acc[1] | acc[0]};
      e    = e + 10'd1;
    end else begin
      norm = acc[26:0] << lz_lim;
      e    = e - {5'd0, lz_lim};
    end

    // norm[2:0] = guard, round, sticky.
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    e_out  = rnd[24] ? (e + 10'd1) : (rnd[23] ? e : 10'd0);

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      sum = 32'h7FC0_0000;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (acc == 28'd0) begin
      sum = {big[31] & sml[31], 31'd0};
    end else if (e_out >= 10'd255) begin
      sum = {big[31], 8'hFF, 23'd0};
    end else begin
      sum = {big[31], e_out[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req    - request vector
//   ptr    - highest-priority index
//   en     - grant enable; gnt is all-zero when low
//   gnt    - one-hot grant
//   gnt_id - index of the winning request (valid when gnt is nonzero)
module rr_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  rr_pick_t           pick;
  logic [MAX_REQ-1:0] req_w;
  logic [2:0]         ptr_w;

  always_comb begin
    req_w                = '0;
    req_w[NUM_REQ-1:0]   = req;
    ptr_w                = '0;
    ptr_w[ID_W-1:0]      = ptr;
    pick                 = rr_pick(req_w, ptr_w, NUM_REQ);
    gnt                  = (en && pick.found) ? (NUM_REQ'(1) << pick.idx) : '0;
    gnt_id               = pick.idx[ID_W-1:0];
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one floatAdder among NUM_REQ requesters.
// A round-robin winner's operand pair is registered, added during EXEC and
// the registered sum is returned with the requester ID; one op in flight.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester handshake (req_ready is one-hot)
//   req_a, req_b        - packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready - response handshake
//   rsp_data, rsp_id    - sum and issuing requester index
//   busy                - operation in EXEC or RESP
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy
);

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q, rsp_id_q, gnt_id, rr_ptr_d;
  logic [FP_W-1:0]    op_a_q, op_b_q, rsp_data_q, sum, a_sel, b_sel;
  logic               rsp_valid_q, busy_q, arb_en, grant;
  logic [NUM_REQ-1:0] gnt;

  // Grants only when nothing is held, or the held result leaves this cycle.
  assign arb_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign grant     = |gnt;
  assign req_ready = gnt;
  assign rr_ptr_d  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*FP_W +: FP_W];
        b_sel = req_b[i*FP_W +: FP_W];
      end
    end
  end

  floatAdder u_float_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            op_a_q   <= a_sel;
            op_b_q   <= b_sel;
            rsp_id_q <= gnt_id;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= sum;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (grant) begin
              // Back-to-back: accept overlaps the next grant.
              op_a_q   <= a_sel;
              op_b_q   <= b_sel;
              rsp_id_q <= gnt_id;
              rr_ptr_q <= rr_ptr_d;
              state_q  <= EXEC;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: scoreboard of expected responses fed at
// grant time from a behavioural model (real-valued addition rounded to
// single precision, round-robin search over a requester list).
module tb_fp_add_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ready;
  logic         busy;

  logic [31:0]  opa [N];
  logic [31:0]  opb [N];

  assign req_a = {opa[3], opa[2], opa[1], opa[0]};
  assign req_b = {opb[3], opb[2], opb[1], opb[0]};

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          grant_log[$];
  int          npass = 0;
  int          ntot  = 0;
  int          ptr_m = 0;
  int          cyc   = 0;
  int          gcyc  = 0;
  int          pend  = -1;
  int          nrsp  = 0;
  bit          inflight = 1'b0;
  bit          regen    = 1'b0;
  logic [3:0]  s_rdy;
  logic        s_rv;
  logic [31:0] s_data;
  logic [1:0]  s_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Single-precision value of a normal operand, exact in double.
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    m = real'({1'b1, f[22:0]});
    e = int'(f[30:23]) - 150;
    m = m * (2.0 ** e);
    return f[31] ? -m : m;
  endfunction

  // Round an exact double (normal single range) to single, nearest-even.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] keep;
    logic [28:0] rem;
    int          ee;
    if (r == 0.0) return 32'h0;
    d    = $realtobits(r);
    ee   = int'(d[62:52]) - 1023 + 127;
    keep = {2'b01, d[51:29]};
    rem  = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      ee   = ee + 1;
      keep = keep >> 1;
    end
    return {d[63], 8'(ee), keep[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(140, 120));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic new_ops(input int i);
    opa[i] = rnd_fp();
    case ($urandom % 8)
      0:       opb[i] = opa[i] ^ 32'h8000_0000;
      1:       opb[i] = {~opa[i][31], opa[i][30:0] + 31'($urandom_range(64, 1))};
      default: opb[i] = rnd_fp();
    endcase
  endtask

  // Model one cycle: inputs are settled, the next rising edge acts on them.
  task automatic step();
    bit avail, can;
    int win, idx;
    exp_t e;
    avail  = inflight && (cyc >= gcyc + 2);
    s_rdy  = req_ready;
    s_rv   = rsp_valid;
    s_data = rsp_data;
    s_id   = rsp_id;
    chk("rsp_valid", 32'(rsp_valid), 32'(avail));
    chk("busy", 32'(busy), 32'(inflight));
    can = !inflight || (avail && rsp_ready);
    win = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    chk("req_ready", 32'(req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
    for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
    if (avail && rsp_ready) inflight = 1'b0;
    if (win >= 0) begin
      e.id   = 2'(win);
      e.data = ref_add(opa[win], opb[win]);
      sbq.push_back(e);
      ptr_m    = (win + 1) % N;
      inflight = 1'b1;
      gcyc     = cyc;
      if (regen) pend = win;
    end
    cyc++;
  endtask

  task automatic cycle(input logic [3:0] v, input logic rr);
    @(negedge clk);
    if (pend >= 0) begin
      new_ops(pend);
      pend = -1;
    end
    req_valid = v;
    rsp_ready = rr;
    #1;
    step();
  endtask

  task automatic drain();
    int n;
    regen = 1'b0;
    n = 0;
    cycle(4'b0000, 1'b1);
    while (inflight && n < 10) begin
      cycle(4'b0000, 1'b1);
      n++;
    end
    if (inflight) begin
      ntot++;
      $display("FAIL drain_timeout: op still in flight after %0d cycles, expected idle", n);
    end
  endtask

  // Response monitor: pops the scoreboard on every accepted response and
  // checks that a stalled response does not change.
  initial begin : monitor
    logic        held;
    logic [31:0] hd;
    logic [1:0]  hid;
    exp_t        e;
    held = 1'b0;
    hd   = '0;
    hid  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid) begin
        if (held) begin
          chk("hold_data", rsp_data, hd);
          chk("hold_id", 32'(rsp_id), 32'(hid));
        end
        if (rsp_ready) begin
          held = 1'b0;
          if (sbq.size() == 0) begin
            ntot++;
            $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
          end else begin
            e = sbq.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", rsp_data, e.data);
            nrsp++;
          end
        end else begin
          held = 1'b1;
          hd   = rsp_data;
          hid  = rsp_id;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int start;
    real r;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end

    // Reset and idle
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      cycle(4'b0000, 1'b0);
      chk("idle_rsp_data", s_data, 32'd0);
      chk("idle_rsp_id", 32'(s_id), 32'd0);
    end

    // Single op: 1.0 + 2.0 from requester 2
    opa[2] = 32'h3F80_0000;
    opb[2] = 32'h4000_0000;
    cycle(4'b0100, 1'b1);
    chk("single_grant", 32'(s_rdy), 32'h4);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("single_rsp_valid", 32'(s_rv), 32'd1);
    chk("single_rsp_data", s_data, 32'h4040_0000);
    chk("single_rsp_id", 32'(s_id), 32'd2);
    drain();

    // Mixed sign: 105.45 + (-22.32) from requester 1
    opa[1] = 32'h42D2_E666;
    opb[1] = 32'hC1B2_8F5C;
    cycle(4'b0010, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("mixed_rsp_id", 32'(s_id), 32'd1);
    chk("mixed_rsp_data", s_data, ref_add(32'h42D2_E666, 32'hC1B2_8F5C));
    r = f2r(s_data);
    chk("mixed_approx", 32'(r > 83.12 && r < 83.14), 32'd1);
    drain();

    // Round-robin fairness with every requester valid
    for (int i = 0; i < N; i++) new_ops(i);
    regen = 1'b1;
    start = ptr_m;
    grant_log.delete();
    repeat (16) cycle(4'b1111, 1'b1);
    chk("rr_grant_count", 32'(grant_log.size()), 32'd8);
    foreach (grant_log[k]) chk("rr_order", 32'(grant_log[k]), 32'((start + k) % N));
    drain();

    // Backpressure: hold the response 5 cycles while requester 0 waits
    new_ops(3);
    new_ops(0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    repeat (5) begin
      cycle(4'b0001, 1'b0);
      chk("bp_rsp_valid", 32'(s_rv), 32'd1);
      chk("bp_req_ready", 32'(s_rdy), 32'd0);
    end
    cycle(4'b0001, 1'b1);
    chk("bp_regrant", 32'(s_rdy), 32'h1);
    drain();

    // Reset during EXEC: op discarded, pointer back to 0
    new_ops(2);
    cycle(4'b0100, 1'b1);
    @(negedge clk);
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    inflight = 1'b0;
    ptr_m    = 0;
    repeat (3) cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1);
    chk("post_rst_grant", 32'(s_rdy), 32'h1);
    drain();

    // Randomized traffic with random valids and backpressure
    for (int i = 0; i < N; i++) new_ops(i);
    regen = 1'b1;
    repeat (600) cycle(4'($urandom), ($urandom % 4) != 0);
    drain();
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("rsp_seen", 32'(nrsp > 50), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
